padc_dig_correct: RTL and testbench
===================================

// Module: padc_dig_correct
// PURPOSE
//  Digital back-end of the pipelined ADC model; consumes the per-stage 1.5-bit raw codes from the
//  analog stage chain. Stage i resolves a given sample i cycles after stage 0, so the block
//  time-aligns the NSTAGES codes with per-stage delay lines. It then applies overlap-add digital
//  error correction and emits one registered (NSTAGES+1)-bit conversion word per valid sample.
//  Also counts illegal stage codes.
// PARAMETERS
//  NSTAGES   7   number of 1.5-bit stages; output width OW = NSTAGES+1
//  TWOS_COMP 0   0: offset-binary dout; 1: two's complement (dout MSB inverted)
//  ERRW      8   width of illegal-code error counter
// PORTS
//  clk      in   1         single clock; everything is sampled on its rising edge
//  rst      in   1         reset; synchronous, active-high
//  raw_vld  in   1         stage-0 code in dig_raw[0] belongs to a new sample this cycle
//  dig_raw  in   2 x NST   unpacked [NSTAGES] raw stage codes; legal 0,1,2; 2'b11 illegal
//  err_clr  in   1         synchronous clear of err_cnt and err_sticky
//  dout     out  OW        corrected conversion word
//  dout_vld out  1         one-cycle strobe: dout is valid
//  err_cnt  out  ERRW      count of illegal codes that entered the correction adder; saturates at all-ones
//  err_sticky out 1        set on any counted illegal code; held until err_clr or rst
// BEHAVIOUR
//  - Reset (rst=1 at an edge): dout=0, dout_vld=0, err_cnt=0, err_sticky=0.
//    All delay-line and valid-pipeline registers are cleared.
//    Reset mid-conversion discards every in-flight sample; no dout_vld for them.
//  - Alignment: dig_raw[i] passes through D(i)=NSTAGES-1-i register stages. Stage NSTAGES-1 has 0 delay.
//    raw_vld passes through a NSTAGES-1 deep valid shift register.
//    All lines shift every cycle; there is no stall.
//  - Sample n: codes are dig_raw[i] captured at cycle t0+i, where t0 is the cycle raw_vld=1.
//  - Code sanitise: applied after alignment. An aligned code of 2'b11 is replaced by 2'b10.
//    It is counted as an error only if the aligned valid bit is 1.
//  - Correction: sum = SUM_i code_i * 2^(NSTAGES-1-i), computed in OW bits.
//    Max value 2^OW-2, so there is no overflow and no clamp.
//    TWOS_COMP=1: dout = {~sum[OW-1], sum[OW-2:0]}.
//  - Output register: dout/dout_vld are registered from the aligned valid.
//    Latency from the t0 edge to the dout_vld=1 edge is NSTAGES cycles (6 align + 1 adder).
//    dout updates only when the aligned valid is 1; otherwise it holds its previous value.
//  - Back-to-back raw_vld every cycle gives dout_vld every cycle (throughput 1/clk).
//  - err_cnt:
//    - +1 per valid sample, if any of that sample's aligned codes is illegal (one increment per sample, not per stage).
//    - Saturates at 2^ERRW-1.
//  - err_clr and a counted error in the same cycle: clear wins; the result is 0 and sticky stays 0.
//  - raw_vld=0 cycles are bubbles: the codes still shift through but are ignored; no error counting.
// TESTING (NSTAGES=7, TWOS_COMP=0 unless stated)
//  1. All stages code 1 for one sample (each at its staggered cycle), raw_vld at t0.
//     -> dout=8'h7F, dout_vld high only at t0+7.
//  2. All codes 2 -> dout=8'hFE; all codes 0 -> dout=8'h00.
//     Repeat case 1 with TWOS_COMP=1 -> dout=8'hFF.
//  3. Stagger check: sample A (stage0=2, other stages 0) at t0, sample B (all 1) at t0+1.
//     -> dout=8'h80 at t0+7, then 8'h7F at t0+8; confirms no cross-sample mixing.
//  4. Stage 3 code 2'b11 for a valid sample, other stages 1.
//     -> treated as 2, dout=8'h87, err_cnt=1, err_sticky=1.
//     Same code during a bubble -> no count.
//  5. 300 consecutive illegal samples -> err_cnt saturates at 8'hFF.
//     err_clr coincident with a new error -> err_cnt=0, err_sticky=0.
//  6. rst pulsed at t0+3 with 3 samples in flight -> no dout_vld for them.
//     Outputs read 0 from the edge after rst; a new sample after reset gives the correct dout at +7.

Source files
------------

// File: rtl/padc_dig_correct_if.sv
// Stage-code / conversion-word bundle between the analog stage chain model and the digital back-end.
interface padc_dig_correct_if #(
  parameter int unsigned NSTAGES = 7,
  parameter int unsigned ERRW    = 8
);
  localparam int unsigned OW = NSTAGES + 1;

  logic            raw_vld;
  logic [1:0]      dig_raw [NSTAGES];
  logic            err_clr;
  logic [OW-1:0]   dout;
  logic            dout_vld;
  logic [ERRW-1:0] err_cnt;
  logic            err_sticky;

  modport master (
    output raw_vld, dig_raw, err_clr,
    input  dout, dout_vld, err_cnt, err_sticky
  );

  modport slave (
    input  raw_vld, dig_raw, err_clr,
    output dout, dout_vld, err_cnt, err_sticky
  );
endinterface

// File: rtl/padc_dig_correct.sv
// Pipelined-ADC digital back-end: aligns staggered 1.5-bit stage codes, applies
// overlap-add correction and counts illegal codes.
module padc_dig_correct #(
  parameter int unsigned NSTAGES   = 7,
  parameter int unsigned TWOS_COMP = 0,
  parameter int unsigned ERRW      = 8
) (
  input logic              clk,
  input logic              rst,
  padc_dig_correct_if.slave bus
);
  localparam int unsigned OW = NSTAGES + 1;
  localparam int unsigned VD = NSTAGES - 1;

  logic [1:0]      aligned [NSTAGES];
  logic [VD-1:0]   vld_sr;
  logic            vld_al;
  logic [1:0]      code;
  logic            illegal;
  logic [OW-1:0]   sum;
  logic [OW-1:0]   dout_d;
  logic [OW-1:0]   dout_q;
  logic            dout_vld_q;
  logic [ERRW-1:0] err_cnt_q;
  logic            err_sticky_q;

  // Stage i is resolved i cycles after stage 0, so it waits NSTAGES-1-i cycles.
  for (genvar gi = 0; gi < int'(NSTAGES); gi++) begin : g_stage
    localparam int unsigned D = NSTAGES - 1 - gi;
    if (D == 0) begin : g_nodly
      assign aligned[gi] = bus.dig_raw[gi];
    end else begin : g_dly
      logic [1:0] line [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < D; k++) line[k] <= 2'b00;
        end else begin
          line[0] <= bus.dig_raw[gi];
          for (int unsigned k = 1; k < D; k++) line[k] <= line[k-1];
        end
      end
      assign aligned[gi] = line[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= (vld_sr << 1) | VD'(bus.raw_vld);
  end

  assign vld_al = vld_sr[VD-1];

  // Illegal 2'b11 is folded to 2 before the weighted overlap-add.
  always_comb begin
    sum     = '0;
    illegal = 1'b0;
    code    = 2'b00;
    for (int unsigned i = 0; i < NSTAGES; i++) begin
      code    = (aligned[i] == 2'b11) ? 2'b10 : aligned[i];
      illegal = illegal | (aligned[i] == 2'b11);
      sum     = sum + (OW'(code) << (NSTAGES - 1 - i));
    end
  end

  always_comb begin
    dout_d = sum;
    if (TWOS_COMP != 0) dout_d[OW-1] = ~sum[OW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= vld_al;
      if (vld_al) dout_q <= dout_d;
    end
  end

  // Clear beats a same-cycle error; one increment per sample, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else if (bus.err_clr) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else if (vld_al && illegal) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != {ERRW{1'b1}}) err_cnt_q <= err_cnt_q + ERRW'(1);
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_padc_dig_correct.sv
// Directed bench for padc_dig_correct; a small stage-chain model staggers each sample's codes.
module tb_padc_dig_correct;
  localparam int unsigned NST = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_vld;
  logic       err_clr;
  logic [1:0] dig_raw [NST];
  logic [13:0] hist [NST];

  int n_tests = 0;
  int n_fail  = 0;

  padc_dig_correct_if #(.NSTAGES(NST), .ERRW(8)) bus0 ();
  padc_dig_correct_if #(.NSTAGES(NST), .ERRW(8)) bus1 ();

  padc_dig_correct #(.NSTAGES(NST), .TWOS_COMP(0), .ERRW(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  padc_dig_correct #(.NSTAGES(NST), .TWOS_COMP(1), .ERRW(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.raw_vld = raw_vld;
  assign bus0.err_clr = err_clr;
  assign bus0.dig_raw = dig_raw;
  assign bus1.raw_vld = raw_vld;
  assign bus1.err_clr = err_clr;
  assign bus1.dig_raw = dig_raw;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample launched now presents stage i at i cycles later.
  task automatic cyc(input logic v, input logic [13:0] c);
    for (int k = NST - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = c;
    for (int i = 0; i < NST; i++) dig_raw[i] = hist[i][2*i +: 2];
    raw_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 14'h0);
  endtask

  localparam logic [13:0] ALL1 = 14'h1555;
  localparam logic [13:0] ALL2 = 14'h2AAA;
  localparam logic [13:0] ALL0 = 14'h0000;
  localparam logic [13:0] S0_2 = 14'h0002;
  localparam logic [13:0] S3_X = 14'h15D5;
  localparam logic [13:0] S0_X = 14'h0003;

  initial begin
    logic saw_vld;
    rst = 1'b1; raw_vld = 1'b0; err_clr = 1'b0;
    for (int k = 0; k < NST; k++) begin hist[k] = '0; dig_raw[k] = 2'b00; end
    bubbles(3);
    rst = 1'b0;
    chk("rst_dout",   32'(bus0.dout), 32'h00);
    chk("rst_vld",    32'(bus0.dout_vld), 32'h0);
    chk("rst_errcnt", 32'(bus0.err_cnt), 32'h00);
    chk("rst_sticky", 32'(bus0.err_sticky), 32'h0);

    // All codes 1, single sample
    cyc(1'b1, ALL1);
    bubbles(5);
    chk("all1_vld_early", 32'(bus0.dout_vld), 32'h0);
    bubbles(1);
    chk("all1_vld", 32'(bus0.dout_vld), 32'h1);
    chk("all1_dout", 32'(bus0.dout), 32'h7F);
    chk("all1_dout_tc", 32'(bus1.dout), 32'hFF);
    bubbles(1);
    chk("all1_vld_after", 32'(bus0.dout_vld), 32'h0);
    chk("all1_hold", 32'(bus0.dout), 32'h7F);

    // All 2 then all 0 back to back
    cyc(1'b1, ALL2);
    cyc(1'b1, ALL0);
    bubbles(5);
    chk("all2_vld", 32'(bus0.dout_vld), 32'h1);
    chk("all2_dout", 32'(bus0.dout), 32'hFE);
    bubbles(1);
    chk("all0_vld", 32'(bus0.dout_vld), 32'h1);
    chk("all0_dout", 32'(bus0.dout), 32'h00);
    chk("all0_dout_tc", 32'(bus1.dout), 32'h80);
    bubbles(1);
    chk("all0_vld_after", 32'(bus0.dout_vld), 32'h0);

    // Stagger: A (stage0=2) then B (all 1)
    cyc(1'b1, S0_2);
    cyc(1'b1, ALL1);
    bubbles(5);
    chk("stagA_dout", 32'(bus0.dout), 32'h80);
    bubbles(1);
    chk("stagB_dout", 32'(bus0.dout), 32'h7F);
    chk("stagB_vld", 32'(bus0.dout_vld), 32'h1);

    // Illegal stage-3 code on a valid sample, then on a bubble
    cyc(1'b1, S3_X);
    bubbles(6);
    chk("ill_dout", 32'(bus0.dout), 32'h87);
    chk("ill_errcnt", 32'(bus0.err_cnt), 32'h01);
    chk("ill_sticky", 32'(bus0.err_sticky), 32'h1);
    cyc(1'b0, S3_X);
    bubbles(8);
    chk("bubble_errcnt", 32'(bus0.err_cnt), 32'h01);

    // Clear, then saturate with 300 illegal samples
    err_clr = 1'b1;
    bubbles(1);
    err_clr = 1'b0;
    chk("clr_errcnt", 32'(bus0.err_cnt), 32'h00);
    chk("clr_sticky", 32'(bus0.err_sticky), 32'h0);
    for (int k = 0; k < 300; k++) cyc(1'b1, S0_X);
    bubbles(7);
    chk("sat_errcnt", 32'(bus0.err_cnt), 32'hFF);
    chk("sat_sticky", 32'(bus0.err_sticky), 32'h1);

    // err_clr coincident with a counted error
    cyc(1'b1, S0_X);
    bubbles(5);
    chk("pre_clr_errcnt", 32'(bus0.err_cnt), 32'hFF);
    err_clr = 1'b1;
    bubbles(1);
    err_clr = 1'b0;
    chk("coclr_errcnt", 32'(bus0.err_cnt), 32'h00);
    chk("coclr_sticky", 32'(bus0.err_sticky), 32'h0);
    chk("coclr_dout", 32'(bus0.dout), 32'h80);

    // Reset with three samples in flight
    cyc(1'b1, ALL1);
    cyc(1'b1, ALL1);
    cyc(1'b1, ALL1);
    rst = 1'b1;
    bubbles(1);
    rst = 1'b0;
    chk("midrst_dout", 32'(bus0.dout), 32'h00);
    chk("midrst_vld", 32'(bus0.dout_vld), 32'h0);
    saw_vld = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bubbles(1);
      saw_vld = saw_vld | bus0.dout_vld;
    end
    chk("midrst_no_vld", 32'(saw_vld), 32'h0);
    cyc(1'b1, ALL2);
    bubbles(6);
    chk("postrst_vld", 32'(bus0.dout_vld), 32'h1);
    chk("postrst_dout", 32'(bus0.dout), 32'hFE);
    chk("postrst_errcnt", 32'(bus0.err_cnt), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
